// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the seven-segment display scanner.
// Segment vectors are ordered a..g at bits 6..0, active-high.
package seg7_pkg;

  typedef enum logic {SHOW, GAP} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

endpackage

// File: rtl/seg7_decode.sv
// BCD to seven-segment decoder; non-decimal nibbles decode to a blank digit.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner with dead time between digits and a
// pending slot that is committed to the display only at frame boundaries.
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic                    ready,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int MAX_CNT = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int DW      = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // state/idx/cnt describe the cycle that the next edge will put on the pins
  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]           disp_word_q, disp_word_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [DW-1:0]           pend_word_q, pend_word_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic       xfer;
  logic       accept;
  logic [3:0] nibble;
  logic       digit_dp;
  logic       lead_zero;
  logic       suppress;
  logic [6:0] dec_seg;

  seg7_decode u_decode (
    .bcd (nibble),
    .seg (dec_seg)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: state_d = SHOW;
    endcase
  end

  // frame_done_q marks the last cycle of a frame, so its closing edge commits pending
  always_comb begin
    xfer         = frame_done_q && pend_valid_q;
    accept       = load && !pend_valid_q;
    disp_word_d  = xfer ? pend_word_q : disp_word_q;
    disp_dp_d    = xfer ? pend_dp_q : disp_dp_q;
    pend_word_d  = pend_word_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    if (accept) begin
      pend_word_d  = data;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end else if (xfer) begin
      pend_valid_d = 1'b0;
    end
  end

  always_comb begin
    nibble    = 4'd0;
    digit_dp  = 1'b0;
    lead_zero = 1'b1;
    suppress  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nibble   = disp_word_d[4*k +: 4];
        digit_dp = disp_dp_d[k];
      end
    end
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lead_zero = lead_zero && (disp_word_d[4*k +: 4] == 4'd0);
      if ((idx_q == IDX_W'(k)) && lead_zero) suppress = 1'b1;
    end

    an_d         = '0;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b0;
    frame_done_d = (state_q == GAP) && (cnt_q == GAP_LAST) && (idx_q == IDX_LAST);
    if (state_q == SHOW) begin
      an_d  = NUM_DIGITS'(1) << idx_q;
      seg_d = (lz_en && suppress) ? SEG_BLANK : dec_seg;
      dp_d  = digit_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SHOW;
      idx_q        <= '0;
      cnt_q        <= '0;
      disp_word_q  <= '0;
      disp_dp_q    <= '0;
      pend_word_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_word_q  <= disp_word_d;
      disp_dp_q    <= disp_dp_d;
      pend_word_q  <= pend_word_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready      = !pend_valid_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
